// File: rtl/tt_um_alvin_asmar_logic_sequencer.sv
// ============================================================================
// Module   : tt_um_alvin_asmar_logic_sequencer
// Purpose  : Self-checking sequencer for the gate datapath
//            x = (A & B) | ~C, y = ~C. It sweeps or steps the {C,B,A}
//            vector, captures x/y truth tables and flags pass/fail.
// Options  : LOGSEQ_SYNC_EN - two-flop synchronizers on start/step
//            (two-edge input latency). When undefined, start/step use a
//            single input register (one-edge input latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_alvin_asmar_logic_sequencer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] DWELL_RELOAD = 4'(STEP_CYCLES - 1);
  localparam logic [7:0] XTAB_GOLDEN  = 8'h8F;
  localparam logic [7:0] YTAB_GOLDEN  = 8'h0F;

  logic [1:0] state_q, state_d;
  logic [2:0] vec;
  logic [3:0] dwell;
  logic [7:0] xtab, ytab;
  logic       mode;
  logic       start_lvl, step_lvl;
  logic       start_prev, step_prev;
  logic       start_rise, step_rise;
  logic       x, y;
  logic       busy, done, pass;
  logic       unused;

  assign unused = ^{ena, uio_in, ui_in[7:4]};

`ifdef LOGSEQ_SYNC_EN
  logic [1:0] start_sync, step_sync;

  // Two-flop synchronizers for the asynchronous start/step pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= 2'b00;
      step_sync  <= 2'b00;
    end else begin
      start_sync <= {start_sync[0], ui_in[0]};
      step_sync  <= {step_sync[0], ui_in[2]};
    end
  end

  assign start_lvl = start_sync[1];
  assign step_lvl  = step_sync[1];
`else
  logic start_reg, step_reg;

  // Single input register so the event lands one edge after sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg <= 1'b0;
      step_reg  <= 1'b0;
    end else begin
      start_reg <= ui_in[0];
      step_reg  <= ui_in[2];
    end
  end

  assign start_lvl = start_reg;
  assign step_lvl  = step_reg;
`endif

  // Edge-detect flops hold the previous input level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b0;
      step_prev  <= 1'b0;
    end else begin
      start_prev <= start_lvl;
      step_prev  <= step_lvl;
    end
  end

  assign start_rise = start_lvl & ~start_prev;
  assign step_rise  = step_lvl & ~step_prev;

  // Embedded gate datapath under test
  assign x = (vec[0] & vec[1]) | ~vec[2];
  assign y = ~vec[2];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; events illegal in a state are simply not decoded
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_rise) state_d = S_APPLY;
      S_APPLY: begin
        if (dwell == 4'd0) begin
          if (vec == 3'd7) state_d = S_DONE;
          else if (mode)   state_d = S_WAIT;
          else             state_d = S_APPLY;
        end
      end
      S_WAIT:  if (step_rise) state_d = S_APPLY;
      S_DONE:  if (start_rise) state_d = S_APPLY;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; pass is only meaningful once the run has finished
  always_comb begin
    busy = (state_q == S_APPLY) || (state_q == S_WAIT);
    done = (state_q == S_DONE);
    pass = done && (xtab == XTAB_GOLDEN) && (ytab == YTAB_GOLDEN);
  end

  // Vector, dwell counter, mode latch and truth-table capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec   <= 3'd0;
      dwell <= 4'd0;
      xtab  <= 8'h00;
      ytab  <= 8'h00;
      mode  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            xtab  <= 8'h00;
            ytab  <= 8'h00;
            vec   <= 3'd0;
            dwell <= DWELL_RELOAD;
            mode  <= ui_in[1];
          end
        end
        S_APPLY: begin
          if (dwell == 4'd0) begin
            xtab[vec] <= x;
            ytab[vec] <= y;
            if ((vec != 3'd7) && !mode) begin
              vec   <= vec + 3'd1;
              dwell <= DWELL_RELOAD;
            end
          end else begin
            dwell <= dwell - 4'd1;
          end
        end
        S_WAIT: begin
          if (step_rise) begin
            vec   <= vec + 3'd1;
            dwell <= DWELL_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = {pass, done, busy, y, x, vec};
  assign uio_out = ui_in[3] ? ytab : xtab;
  assign uio_oe  = 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_alvin_asmar_logic_sequencer.sv
// ============================================================================
// Module   : tb_tt_um_alvin_asmar_logic_sequencer
// Purpose  : Directed self-checking bench for the logic sequencer
//            (sweep, manual, ignored events, reset mid-run, restart).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_alvin_asmar_logic_sequencer;

`ifdef LOGSEQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  tt_um_alvin_asmar_logic_sequencer #(.STEP_CYCLES(4)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the expected uo_out word
  function automatic logic [7:0] uo_exp(input logic [2:0] v, input logic b,
                                        input logic d, input logic p);
    logic xe, ye;
    xe = (v[0] & v[1]) | ~v[2];
    ye = ~v[2];
    return {p, d, b, ye, xe, v};
  endfunction

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%02h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_tables(input string tag, input logic [7:0] xt,
                              input logic [7:0] yt);
    ui_in[3] = 1'b0;
    #1;
    push({tag, "_xtab"}, xt);
    pop_check(uio_out);
    ui_in[3] = 1'b1;
    #1;
    push({tag, "_ytab"}, yt);
    pop_check(uio_out);
    ui_in[3] = 1'b0;
  endtask

  // One-cycle start pulse; checks the input latency to busy
  task automatic start_pulse(input logic mode);
    ui_in[1] = mode;
    ui_in[0] = 1'b1;
    @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    push("busy_before_latency", 8'h00);
    pop_check({7'd0, uo_out[5]});
    @(negedge clk);
    push("busy_after_latency", 8'h01);
    pop_check({7'd0, uo_out[5]});
    push("first_vector", uo_exp(3'd0, 1'b1, 1'b0, 1'b0));
    pop_check(uo_out);
  endtask

  // Follows a sweep from vec 0 to DONE; optionally injects ignored pulses
  task automatic run_sweep(input logic inject);
    for (int i = 1; i <= 7; i++) begin
      if (inject && (i == 4)) begin
        ui_in[0] = 1'b1;
        ui_in[2] = 1'b1;
        @(negedge clk);
        ui_in[0] = 1'b0;
        ui_in[2] = 1'b0;
        repeat (3) @(negedge clk);
      end else if (inject && (i == 6)) begin
        ui_in[2] = 1'b1;
        @(negedge clk);
        ui_in[2] = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      push($sformatf("sweep_vec%0d", i), uo_exp(3'(i), 1'b1, 1'b0, 1'b0));
      pop_check(uo_out);
    end
    repeat (4) @(negedge clk);
    push("sweep_done", 8'hCF);
    pop_check(uo_out);
    check_tables("sweep", 8'h8F, 8'h0F);
  endtask

  task automatic step_pulse;
    ui_in[2] = 1'b1;
    @(negedge clk);
    ui_in[2] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    repeat (3) @(negedge clk);
    push("reset_uo", 8'h18);
    pop_check(uo_out);
    check_tables("reset", 8'h00, 8'h00);
    push("uio_oe", 8'hFF);
    pop_check(uio_oe);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push("idle_no_stimulus", 8'h18);
    pop_check(uo_out);
    step_pulse();
    repeat (4) @(negedge clk);
    push("idle_step_ignored", 8'h18);
    pop_check(uo_out);

    // Plain sweep
    start_pulse(1'b0);
    run_sweep(1'b0);

    // Restart from DONE, with ignored start/step pulses mid-sweep
    start_pulse(1'b0);
    check_tables("restart", 8'h00, 8'h00);
    run_sweep(1'b1);

    // Asynchronous reset at vec 5, then a clean sweep
    start_pulse(1'b0);
    repeat (20) @(negedge clk);
    push("pre_reset_vec5", uo_exp(3'd5, 1'b1, 1'b0, 1'b0));
    pop_check(uo_out);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset_uo", 8'h18);
    pop_check(uo_out);
    check_tables("async_reset", 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse(1'b0);
    run_sweep(1'b0);

    // Manual mode
    start_pulse(1'b1);
    repeat (4) @(negedge clk);
    push("manual_wait_vec0", uo_exp(3'd0, 1'b1, 1'b0, 1'b0));
    pop_check(uo_out);
    ui_in[1] = 1'b0;
    repeat (6) @(negedge clk);
    push("manual_mode_change_ignored", uo_exp(3'd0, 1'b1, 1'b0, 1'b0));
    pop_check(uo_out);
    for (int i = 1; i <= 7; i++) begin
      step_pulse();
      repeat (LAT) @(negedge clk);
      push($sformatf("manual_step%0d", i), uo_exp(3'(i), 1'b1, 1'b0, 1'b0));
      pop_check(uo_out);
      repeat (4) @(negedge clk);
      if (i == 7) push("manual_done", 8'hCF);
      else        push($sformatf("manual_park%0d", i), uo_exp(3'(i), 1'b1, 1'b0, 1'b0));
      pop_check(uo_out);
    end
    check_tables("manual", 8'h8F, 8'h0F);
    step_pulse();
    repeat (3) @(negedge clk);
    step_pulse();
    repeat (4) @(negedge clk);
    push("done_steps_ignored", 8'hCF);
    pop_check(uo_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
